output_seq_ctrl: RTL and testbench
==================================

Name: output_seq_ctrl

Overview:
- Sequencer for the output pipeline: walks scratchpad read-address pairs and controls the accumulate/fetch stage.
- Issues one group of GROUP read pairs per output word, then one output-memory write. Repeats for num_groups words, then pulses done.
- Sits between the top-level start/config source and the fetch/accumulate datapath, the scratchpad read ports and the output-memory write port.

Parameters:
- ADDR_W, 16, width of all scratchpad and output-memory addresses.
- GROUP, 8, accumulations per output word; power of two, at most 8.
- RD_LAT, 1, scratchpad read latency in cycles; range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- num_groups  in  16  output words in the job; latched on accepted start.
- sp_base1  in  ADDR_W  first read address, bus 1; latched on start.
- sp_base2  in  ADDR_W  first read address, bus 2; latched on start.
- out_base  in  ADDR_W  first output-memory address; latched on start.
- stall  in  1  output memory not ready; holds the WRITE state.
- SP_ReadAddress1  out  ADDR_W  scratchpad read address, bus 1.
- SP_ReadAddress2  out  ADDR_W  scratchpad read address, bus 2.
- acc_en  out  1  accumulate the returning read data this cycle.
- acc_clear  out  1  first accumulation of a group; datapath loads instead of adds.
- store_count  out  3  index (0..GROUP-1) of the current accumulation within its group.
- WriteEnable  out  1  output-memory write strobe.
- Output_MEMAddress  out  ADDR_W  output-memory write address.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE. All outputs and internal counters are 0. Assertion mid-job aborts immediately; no write completes afterwards.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - start with num_groups != 0: latch all config, load both address registers with their bases, go to READ.
  - start with num_groups == 0: go to DONE; no reads, no writes.
  - start while busy is ignored.
- READ:
  - Lasts exactly GROUP cycles.
  - Each cycle presents the current address pair, then increments both registers by 1. Increments wrap modulo 2^ADDR_W.
  - After GROUP cycles, go to DRAIN.
- Accumulate timing:
  - acc_en is the READ-cycle issue flag delayed RD_LAT cycles by a shift register.
  - acc_clear goes with the acc_en of the first issue in the group.
  - store_count goes with each acc_en and counts 0..GROUP-1 in the same delayed pipeline.
  - When acc_en = 0, store_count holds its last value.
- DRAIN:
  - Lasts RD_LAT cycles, until the last acc_en of the group has occurred; then go to WRITE.
  - Address registers hold during DRAIN.
- WRITE:
  - WriteEnable = 1 with Output_MEMAddress = out_base + group index (wraps modulo 2^ADDR_W).
  - If stall = 1: WriteEnable is 0, stay in WRITE, address held.
  - The write completes on the first cycle with stall = 0.
  - Then increment the group index. If the index now equals num_groups, go to DONE; otherwise go to READ.
  - The next group's reads continue from the current address registers (contiguous).
- DONE: done = 1 for exactly one cycle, then return to IDLE.
- Timing with RD_LAT = 1 and no stall:
  - start sampled at cycle 0; READ covers cycles 1..8; DRAIN is cycle 9; WRITE is cycle 10.
  - Each group takes GROUP + RD_LAT + 1 cycles.
  - done is high at cycle (GROUP+RD_LAT+1)*N + 1.
- Registered outputs: all outputs except busy and done are registered. busy and done decode the state register.

Test Plan:
- Reset, then start with num_groups = 1, sp_base1 = 0x0010, sp_base2 = 0x0100, out_base = 0x0040 ->
  - SP_ReadAddress1 = 0x10..0x17 and SP_ReadAddress2 = 0x100..0x107 over cycles 1..8.
  - acc_en at cycles 2..9, with acc_clear only at cycle 2.
  - store_count = 0..7.
  - WriteEnable with address 0x40 at cycle 10.
  - done at cycle 11.
- num_groups = 3, bases 0 -> writes to addresses 0, 1, 2 at cycles 10, 20, 30; reads span 0x00..0x17 contiguously; done at cycle 31.
- num_groups = 1, stall held high for 4 cycles on entering WRITE -> WriteEnable = 0 at cycles 10..13, write at cycle 14, done at cycle 15.
- sp_base1 = 0xFFFC, num_groups = 1 -> SP_ReadAddress1 sequence FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- start with num_groups = 0 -> done at cycle 1; no acc_en and no WriteEnable.
- reset_n asserted during READ of a 2-group job, and a second start while busy -> all outputs are 0 immediately and no write occurs; the start pulse during busy is ignored.

Source files
------------

// File: rtl/output_seq_ctrl_if.sv
// Bundles the sequencer's job config and status, scratchpad read addresses,
// accumulate controls and output-memory write port into one interface.
interface output_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [15:0]       num_groups;
    logic [ADDR_W-1:0] sp_base1;
    logic [ADDR_W-1:0] sp_base2;
    logic [ADDR_W-1:0] out_base;
    logic              stall;

    logic [ADDR_W-1:0] SP_ReadAddress1;
    logic [ADDR_W-1:0] SP_ReadAddress2;
    logic              acc_en;
    logic              acc_clear;
    logic [2:0]        store_count;
    logic              WriteEnable;
    logic [ADDR_W-1:0] Output_MEMAddress;
    logic              busy;
    logic              done;

    // master: job source / datapath side; slave: the sequencer
    modport master (
        output start, num_groups, sp_base1, sp_base2, out_base, stall,
        input  SP_ReadAddress1, SP_ReadAddress2, acc_en, acc_clear, store_count,
               WriteEnable, Output_MEMAddress, busy, done
    );

    modport slave (
        input  start, num_groups, sp_base1, sp_base2, out_base, stall,
        output SP_ReadAddress1, SP_ReadAddress2, acc_en, acc_clear, store_count,
               WriteEnable, Output_MEMAddress, busy, done
    );
endinterface

// File: rtl/output_seq_ctrl.sv
// Output-pipeline sequencer: issues GROUP scratchpad read pairs per output word,
// drives the delayed accumulate controls, then one output-memory write per word.
module output_seq_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned GROUP  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    output_seq_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NG_W  = 16;
    localparam int unsigned LAT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [NG_W-1:0]   grp_q, grp_d;
    logic [NG_W-1:0]   num_groups_q, num_groups_d;
    logic [ADDR_W-1:0] out_base_q, out_base_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] clr_q, clr_d;
    logic [CNT_W-1:0]  idx_q [RD_LAT];
    logic [CNT_W-1:0]  idx_d [RD_LAT];
    logic              issue;
    logic [NG_W-1:0]   grp_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            lat_cnt_q    <= '0;
            grp_q        <= '0;
            num_groups_q <= '0;
            out_base_q   <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            vld_q        <= '0;
            clr_q        <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) idx_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            grp_q        <= grp_d;
            num_groups_q <= num_groups_d;
            out_base_q   <= out_base_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            vld_q        <= vld_d;
            clr_q        <= clr_d;
            for (int i = 0; i < int'(RD_LAT); i++) idx_q[i] <= idx_d[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        grp_d        = grp_q;
        num_groups_d = num_groups_q;
        out_base_d   = out_base_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        waddr_d      = waddr_q;
        issue        = 1'b0;
        grp_inc      = grp_q + NG_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_groups != '0) begin
                        num_groups_d = bus.num_groups;
                        out_base_d   = bus.out_base;
                        addr1_d      = bus.sp_base1;
                        addr2_d      = bus.sp_base2;
                        grp_d        = '0;
                        rd_cnt_d     = '0;
                        state_d      = S_READ;
                    end else begin
                        state_d      = S_DONE;
                    end
                end
            end
            S_READ: begin
                issue    = 1'b1;
                addr1_d  = addr1_q + ADDR_W'(1);
                addr2_d  = addr2_q + ADDR_W'(1);
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == CNT_W'(GROUP - 1)) begin
                    rd_cnt_d  = '0;
                    lat_cnt_d = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_W'(RD_LAT - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                // we_q high means the write is happening this cycle
                if (we_q) begin
                    grp_d   = grp_inc;
                    state_d = (grp_inc == num_groups_q) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered strobe: stall seen now gates the write presented next cycle
        we_d = (state_d == S_WRITE) && !bus.stall;
        if (state_d == S_WRITE) waddr_d = out_base_q + ADDR_W'(grp_q);

        // Issue pipeline; the index holds whenever no valid moves into a stage
        vld_d[0] = issue;
        clr_d[0] = issue && (rd_cnt_q == '0);
        idx_d[0] = issue ? rd_cnt_q : idx_q[0];
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
            clr_d[i] = clr_q[i-1];
            idx_d[i] = vld_q[i-1] ? idx_q[i-1] : idx_q[i];
        end
    end

    assign bus.SP_ReadAddress1   = addr1_q;
    assign bus.SP_ReadAddress2   = addr2_q;
    assign bus.acc_en            = vld_q[RD_LAT-1];
    assign bus.acc_clear         = clr_q[RD_LAT-1];
    assign bus.store_count       = idx_q[RD_LAT-1];
    assign bus.WriteEnable       = we_q;
    assign bus.Output_MEMAddress = waddr_q;
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.done              = (state_q == S_DONE);
endmodule

// File: tb/tb_output_seq_ctrl.sv
// Directed bench for output_seq_ctrl: a per-cycle vector table for a single-group
// job plus hand-written sequences for multi-group, stall, wrap, empty and abort.
module tb_output_seq_ctrl;
    logic clock;
    logic reset_n;

    output_seq_ctrl_if #(.ADDR_W(16)) bus ();

    output_seq_ctrl #(.ADDR_W(16), .GROUP(8), .RD_LAT(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        stall;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        acc;
        logic        clr;
        logic [2:0]  sc;
        logic        we;
        logic [15:0] wa;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [13];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(logic st, logic sl, logic [15:0] a1, logic [15:0] a2, logic acc,
                                logic clr, logic [2:0] sc, logic we, logic [15:0] wa,
                                logic busy, logic done);
        vec_t v;
        v.start = st; v.stall = sl; v.a1 = a1; v.a2 = a2; v.acc = acc; v.clr = clr;
        v.sc = sc; v.we = we; v.wa = wa; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic cfg(input logic [15:0] ng, input logic [15:0] b1, input logic [15:0] b2,
                       input logic [15:0] ob);
        bus.num_groups = ng; bus.sp_base1 = b1; bus.sp_base2 = b2; bus.out_base = ob;
    endtask

    logic [15:0] wrap_exp [8];

    initial begin
        // single group, bases 0x10/0x100, out 0x40: cycle-by-cycle expectations
        vecs[0]  = mk(1, 0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0010, 16'h0100, 0, 0, 3'd0, 0, 16'h0000, 1, 0);
        vecs[2]  = mk(0, 0, 16'h0011, 16'h0101, 1, 1, 3'd0, 0, 16'h0000, 1, 0);
        vecs[3]  = mk(0, 0, 16'h0012, 16'h0102, 1, 0, 3'd1, 0, 16'h0000, 1, 0);
        vecs[4]  = mk(0, 0, 16'h0013, 16'h0103, 1, 0, 3'd2, 0, 16'h0000, 1, 0);
        vecs[5]  = mk(0, 0, 16'h0014, 16'h0104, 1, 0, 3'd3, 0, 16'h0000, 1, 0);
        vecs[6]  = mk(0, 0, 16'h0015, 16'h0105, 1, 0, 3'd4, 0, 16'h0000, 1, 0);
        vecs[7]  = mk(0, 0, 16'h0016, 16'h0106, 1, 0, 3'd5, 0, 16'h0000, 1, 0);
        vecs[8]  = mk(0, 0, 16'h0017, 16'h0107, 1, 0, 3'd6, 0, 16'h0000, 1, 0);
        vecs[9]  = mk(0, 0, 16'h0018, 16'h0108, 1, 0, 3'd7, 0, 16'h0000, 1, 0);
        vecs[10] = mk(0, 0, 16'h0018, 16'h0108, 0, 0, 3'd7, 1, 16'h0040, 1, 0);
        vecs[11] = mk(0, 0, 16'h0018, 16'h0108, 0, 0, 3'd7, 0, 16'h0040, 1, 1);
        vecs[12] = mk(0, 0, 16'h0018, 16'h0108, 0, 0, 3'd7, 0, 16'h0040, 0, 0);

        wrap_exp = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

        bus.start = 1'b0; bus.stall = 1'b0;
        cfg(16'd0, 16'h0, 16'h0, 16'h0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_a1", 0, 32'(bus.SP_ReadAddress1), 32'h0);
        chk("rst_a2", 0, 32'(bus.SP_ReadAddress2), 32'h0);
        chk("rst_acc", 0, 32'(bus.acc_en), 32'h0);
        chk("rst_clr", 0, 32'(bus.acc_clear), 32'h0);
        chk("rst_sc", 0, 32'(bus.store_count), 32'h0);
        chk("rst_we", 0, 32'(bus.WriteEnable), 32'h0);
        chk("rst_wa", 0, 32'(bus.Output_MEMAddress), 32'h0);
        chk("rst_busy", 0, 32'(bus.busy), 32'h0);
        chk("rst_done", 0, 32'(bus.done), 32'h0);
        reset_n = 1'b1;

        // Test 1: table-driven single-group job
        cfg(16'd1, 16'h0010, 16'h0100, 16'h0040);
        for (int c = 0; c < 13; c++) begin
            @(posedge clock); #1;
            bus.start = vecs[c].start;
            bus.stall = vecs[c].stall;
            @(negedge clock);
            chk("t1_a1", c, 32'(bus.SP_ReadAddress1), 32'(vecs[c].a1));
            chk("t1_a2", c, 32'(bus.SP_ReadAddress2), 32'(vecs[c].a2));
            chk("t1_acc", c, 32'(bus.acc_en), 32'(vecs[c].acc));
            chk("t1_clr", c, 32'(bus.acc_clear), 32'(vecs[c].clr));
            chk("t1_sc", c, 32'(bus.store_count), 32'(vecs[c].sc));
            chk("t1_we", c, 32'(bus.WriteEnable), 32'(vecs[c].we));
            if (vecs[c].we) chk("t1_wa", c, 32'(bus.Output_MEMAddress), 32'(vecs[c].wa));
            chk("t1_busy", c, 32'(bus.busy), 32'(vecs[c].busy));
            chk("t1_done", c, 32'(bus.done), 32'(vecs[c].done));
        end

        // Test 2: three groups, bases 0, contiguous reads, writes at 10/20/30
        cfg(16'd3, 16'h0, 16'h0, 16'h0);
        for (int c = 0; c <= 32; c++) begin
            @(posedge clock); #1;
            bus.start = (c == 0);
            @(negedge clock);
            chk("t2_we", c, 32'(bus.WriteEnable), 32'(c == 10 || c == 20 || c == 30));
            if (c == 10 || c == 20 || c == 30)
                chk("t2_wa", c, 32'(bus.Output_MEMAddress), 32'(c / 10 - 1));
            chk("t2_done", c, 32'(bus.done), 32'(c == 31));
            if (c >= 1 && c <= 30 && ((c - 1) % 10) < 8) begin
                chk("t2_a1", c, 32'(bus.SP_ReadAddress1), 32'(8 * ((c - 1) / 10) + (c - 1) % 10));
                chk("t2_a2", c, 32'(bus.SP_ReadAddress2), 32'(8 * ((c - 1) / 10) + (c - 1) % 10));
            end
        end

        // Test 3: stall sampled high four times on entry to WRITE
        cfg(16'd1, 16'h0020, 16'h0200, 16'h0033);
        for (int c = 0; c <= 16; c++) begin
            @(posedge clock); #1;
            bus.start = (c == 0);
            bus.stall = (c >= 9 && c <= 12);
            @(negedge clock);
            if (c >= 10) begin
                chk("t3_we", c, 32'(bus.WriteEnable), 32'(c == 14));
                chk("t3_done", c, 32'(bus.done), 32'(c == 15));
            end
            if (c == 14) chk("t3_wa", c, 32'(bus.Output_MEMAddress), 32'h0033);
        end
        bus.stall = 1'b0;

        // Test 4: read address wrap at 16 bits
        cfg(16'd1, 16'hFFFC, 16'h0000, 16'h0000);
        for (int c = 0; c <= 12; c++) begin
            @(posedge clock); #1;
            bus.start = (c == 0);
            @(negedge clock);
            if (c >= 1 && c <= 8) chk("t4_a1", c, 32'(bus.SP_ReadAddress1), 32'(wrap_exp[c-1]));
            if (c == 11) chk("t4_done", c, 32'(bus.done), 32'h1);
        end

        // Test 5: empty job completes immediately
        cfg(16'd0, 16'h0100, 16'h0100, 16'h0100);
        for (int c = 0; c <= 4; c++) begin
            @(posedge clock); #1;
            bus.start = (c == 0);
            @(negedge clock);
            chk("t5_done", c, 32'(bus.done), 32'(c == 1));
            chk("t5_busy", c, 32'(bus.busy), 32'(c == 1));
            chk("t5_acc", c, 32'(bus.acc_en), 32'h0);
            chk("t5_we", c, 32'(bus.WriteEnable), 32'h0);
        end

        // Test 6: start ignored while busy, then reset mid-READ of group 2
        cfg(16'd2, 16'h0200, 16'h0300, 16'h0080);
        for (int c = 0; c <= 12; c++) begin
            @(posedge clock); #1;
            bus.start = (c == 0 || c == 3);
            if (c == 3) cfg(16'd1, 16'h0555, 16'h0666, 16'h0777);
            @(negedge clock);
            if (c == 4) chk("t6_ign_a1", c, 32'(bus.SP_ReadAddress1), 32'h0203);
            if (c == 10) begin
                chk("t6_we", c, 32'(bus.WriteEnable), 32'h1);
                chk("t6_wa", c, 32'(bus.Output_MEMAddress), 32'h0080);
            end
            if (c == 11) begin
                chk("t6_done", c, 32'(bus.done), 32'h0);
                chk("t6_busy", c, 32'(bus.busy), 32'h1);
                chk("t6_a1", c, 32'(bus.SP_ReadAddress1), 32'h0208);
            end
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_a1", 13, 32'(bus.SP_ReadAddress1), 32'h0);
        chk("t6_rst_a2", 13, 32'(bus.SP_ReadAddress2), 32'h0);
        chk("t6_rst_acc", 13, 32'(bus.acc_en), 32'h0);
        chk("t6_rst_sc", 13, 32'(bus.store_count), 32'h0);
        chk("t6_rst_we", 13, 32'(bus.WriteEnable), 32'h0);
        chk("t6_rst_wa", 13, 32'(bus.Output_MEMAddress), 32'h0);
        chk("t6_rst_busy", 13, 32'(bus.busy), 32'h0);
        chk("t6_rst_done", 13, 32'(bus.done), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            chk("t6_post_we", c, 32'(bus.WriteEnable), 32'h0);
            chk("t6_post_busy", c, 32'(bus.busy), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
